// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: control sequencer for a 16-point radix-2 DIT FFT.
// Walks 4 stages x 8 butterflies, then waits BFLY_LAT cycles per stage.
// Ports:
//   i_clk, i_rst_n (async active-low), i_start, i_stall
//   o_busy, o_bfly_en, o_stage[1:0], o_addr_a[3:0], o_addr_b[3:0],
//   o_twiddle_idx[2:0], o_stage_done, o_done
//   o_cycles[7:0] only when FFT_SEQ_PERF_EN is defined
// Parameters: DIV_LOG2 (0..3) strobe divider, BFLY_LAT (1..15) drain.
`timescale 1ns/1ps
module fft_stage_sequencer #(
  parameter int DIV_LOG2 = 1,
  parameter int BFLY_LAT = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stall,
  output logic       o_busy,
  output logic       o_bfly_en,
  output logic [1:0] o_stage,
  output logic [3:0] o_addr_a,
  output logic [3:0] o_addr_b,
  output logic [2:0] o_twiddle_idx,
  output logic       o_stage_done,
  output logic       o_done
`ifdef FFT_SEQ_PERF_EN
  ,
  output logic [7:0] o_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] PRE_MAX = 3'((1 << DIV_LOG2) - 1);
  localparam logic [3:0] LAT_MAX = 4'(BFLY_LAT - 1);

  state_t     state;
  state_t     state_n;
  logic [1:0] stage;
  logic [1:0] stage_n;
  logic [2:0] k;
  logic [2:0] k_n;
  logic [2:0] pre;
  logic [2:0] pre_n;
  logic [3:0] drain;
  logic [3:0] drain_n;
  logic [3:0] addr_a;
  logic [3:0] addr_b;
  logic [2:0] tw;
  logic [10:0] gen;

  logic strobe;
  logic drain_end;

  // Butterfly operands for stage s, index kk.
  // Packed as {addr_a, addr_b, twiddle}.
  function automatic logic [10:0] bfly_addr(
    input logic [1:0] s,
    input logic [2:0] kk
  );
    logic [3:0] span;
    logic [3:0] grp;
    logic [3:0] pos;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] t;
    span = 4'd1 << s;
    grp  = {1'b0, kk} >> s;
    pos  = {1'b0, kk} & (span - 4'd1);
    a    = ((grp << s) << 1) + pos;
    b    = a + span;
    t    = pos[2:0] << (2'd3 - s);
    return {a, b, t};
  endfunction

  assign strobe    = (state == RUN) && !i_stall
                  && (pre == PRE_MAX);
  assign drain_end = (state == DRAIN)
                  && (drain == LAT_MAX);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (i_start) state_n = RUN;
      end
      RUN: begin
        if (strobe && (k == 3'd7)) state_n = DRAIN;
      end
      DRAIN: begin
        if (drain_end) begin
          state_n = (stage == 2'd3) ? DONE : RUN;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counter next values
  always_comb begin
    stage_n = stage;
    k_n     = k;
    pre_n   = pre;
    drain_n = drain;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          stage_n = 2'd0;
          k_n     = 3'd0;
          pre_n   = 3'd0;
          drain_n = 4'd0;
        end
      end
      RUN: begin
        drain_n = 4'd0;
        if (!i_stall) begin
          pre_n = (pre == PRE_MAX) ? 3'd0
                                   : pre + 3'd1;
        end
        // k wraps to 0 after the last butterfly
        if (strobe) k_n = k + 3'd1;
      end
      DRAIN: begin
        drain_n = drain + 4'd1;
        if (drain_end) begin
          drain_n = 4'd0;
          k_n     = 3'd0;
          pre_n   = 3'd0;
          if (stage != 2'd3) stage_n = stage + 2'd1;
        end
      end
      DONE: begin
        stage_n = 2'd0;
        k_n     = 3'd0;
        pre_n   = 3'd0;
        drain_n = 4'd0;
      end
      default: begin
        stage_n = 2'd0;
        k_n     = 3'd0;
        pre_n   = 3'd0;
        drain_n = 4'd0;
      end
    endcase
  end

  // Addresses are generated from the next stage/k so the
  // registered values line up with the strobe cycle.
  assign gen = bfly_addr(stage_n, k_n);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage  <= 2'd0;
      k      <= 3'd0;
      pre    <= 3'd0;
      drain  <= 4'd0;
      addr_a <= 4'd0;
      addr_b <= 4'd0;
      tw     <= 3'd0;
    end else begin
      stage  <= stage_n;
      k      <= k_n;
      pre    <= pre_n;
      drain  <= drain_n;
      addr_a <= gen[10:7];
      addr_b <= gen[6:3];
      tw     <= gen[2:0];
    end
  end

`ifdef FFT_SEQ_PERF_EN
  logic [7:0] cycles;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycles <= 8'd0;
    end else if (state == IDLE) begin
      if (i_start) cycles <= 8'd0;
    end else if (cycles != 8'hFF) begin
      cycles <= cycles + 8'd1;
    end
  end

  assign o_cycles = cycles;
`endif

  // Output logic
  always_comb begin
    o_busy        = (state != IDLE);
    o_bfly_en     = strobe;
    o_stage       = stage;
    o_addr_a      = addr_a;
    o_addr_b      = addr_b;
    o_twiddle_idx = tw;
    o_stage_done  = drain_end;
    o_done        = (state == DONE);
  end

endmodule
